// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding, widths and constants for the SPI slave sequencer
package spi_pkg;

  localparam int   DEF_ADDR_W = 7;
  localparam int   DEF_DATA_W = 8;
  localparam logic RW_READ    = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_RD_WAIT,
    S_RD_LOAD,
    S_RD_SHIFT,
    S_WR_DATA,
    S_WR_COMMIT,
    S_DONE
  } spi_state_e;

  // bit counter must reach the longer of the header and data phases
  function automatic int cnt_width(input int addr_w, input int data_w);
    int longest;
    longest = (addr_w + 1 > data_w) ? addr_w + 1 : data_w;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/spi_slave_ctrl_if.sv
// rtl/spi_slave_ctrl_if.sv - conditioned SPI pins plus data memory port of the SPI slave sequencer
interface spi_slave_ctrl_if #(
  parameter int ADDR_W = spi_pkg::DEF_ADDR_W,
  parameter int DATA_W = spi_pkg::DEF_DATA_W
);

  logic              cs_n;
  logic              sclk_rise;
  logic              sclk_fall;
  logic              mosi;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic              miso;
  logic              miso_oe;

  modport master (
    output cs_n, sclk_rise, sclk_fall, mosi, rd_data,
    input  mem_addr, wr_data, wr_en, miso, miso_oe
  );

  modport slave (
    input  cs_n, sclk_rise, sclk_fall, mosi, rd_data,
    output mem_addr, wr_data, wr_en, miso, miso_oe
  );

endinterface

// File: rtl/spi_shiftreg.sv
// rtl/spi_shiftreg.sv - parallel-load, serial-in at LSB, serial-out at MSB shift register
module spi_shiftreg #(
  parameter int DATA_W = spi_pkg::DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              shift_en,
  input  logic              sin,
  output logic [DATA_W-1:0] q
);

  // parallel load has priority; a shift moves every bit one place towards the MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift_en) begin
      q <= {q[DATA_W-2:0], sin};
    end
  end

endmodule

// File: rtl/spi_slave_ctrl.sv
// rtl/spi_slave_ctrl.sv - SPI mode 0 slave transaction sequencer; SPI_BURST_EN enables auto-increment bursts
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_slave_ctrl_if.slave  bus
);

  // header shares the data shift register, so ADDR_W+1 must not exceed DATA_W
  localparam int CNT_W = cnt_width(ADDR_W, DATA_W);

  spi_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              wr_en_q;
  logic              miso_oe_q;
  logic              launched;
  logic              sr_load;
  logic              sr_shift;
  logic              sr_sin;
  logic [DATA_W-1:0] sr_q;
  logic [DATA_W-1:0] hdr_word;

  // header as it stands including the bit arriving on the current rise
  assign hdr_word = {sr_q[DATA_W-2:0], bus.mosi};

  spi_shiftreg #(.DATA_W(DATA_W)) u_shiftreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (sr_load),
    .load_data (bus.rd_data),
    .shift_en  (sr_shift),
    .sin       (sr_sin),
    .q         (sr_q)
  );

  assign bus.mem_addr = mem_addr_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.miso_oe  = miso_oe_q;
  assign bus.miso     = sr_q[DATA_W-1];
  assign bus.wr_data  = sr_q;

  // shift register control: capture MOSI on rises, load read data, launch MISO bits on falls
  always_comb begin
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    sr_sin   = 1'b0;
    if (!bus.cs_n) begin
      case (state)
        S_HDR, S_WR_DATA: begin
          sr_shift = bus.sclk_rise;
          sr_sin   = bus.mosi;
        end
        S_RD_LOAD:  sr_load  = 1'b1;
        // the first fall only launches the MSB already sitting in the register
        S_RD_SHIFT: sr_shift = bus.sclk_fall && !bus.sclk_rise && launched;
        default: ;
      endcase
    end
  end

  // transaction FSM with bit counter, address register and registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      mem_addr_q <= '0;
      wr_en_q    <= 1'b0;
      miso_oe_q  <= 1'b0;
      launched   <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      if (bus.cs_n) begin
        state     <= S_IDLE;
        cnt       <= '0;
        miso_oe_q <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            state <= S_HDR;
            cnt   <= '0;
          end
          S_HDR: begin
            if (bus.sclk_rise) begin
              if (cnt == CNT_W'(ADDR_W)) begin
                cnt        <= '0;
                mem_addr_q <= hdr_word[ADDR_W:1];
                state      <= (hdr_word[0] == RW_READ) ? S_RD_WAIT : S_WR_DATA;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          S_RD_WAIT: begin
            state     <= S_RD_LOAD;
            miso_oe_q <= 1'b1;
          end
          S_RD_LOAD: begin
            state    <= S_RD_SHIFT;
            launched <= 1'b0;
          end
          S_RD_SHIFT: begin
            if (bus.sclk_rise) begin
              if (cnt == CNT_W'(DATA_W-1)) begin
                cnt <= '0;
`ifdef SPI_BURST_EN
                state      <= S_RD_WAIT;
                mem_addr_q <= mem_addr_q + ADDR_W'(1);
`else
                state     <= S_DONE;
                miso_oe_q <= 1'b0;
`endif
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end else if (bus.sclk_fall) begin
              launched <= 1'b1;
            end
          end
          S_WR_DATA: begin
            if (bus.sclk_rise) begin
              if (cnt == CNT_W'(DATA_W-1)) begin
                cnt     <= '0;
                state   <= S_WR_COMMIT;
                wr_en_q <= 1'b1;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          S_WR_COMMIT: begin
`ifdef SPI_BURST_EN
            state      <= S_WR_DATA;
            mem_addr_q <= mem_addr_q + ADDR_W'(1);
`else
            state <= S_DONE;
`endif
          end
          S_DONE:  state <= S_DONE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // a rise and a fall in the same clk cannot come from one conditioned SCLK; the rise wins
  a_single_edge: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.sclk_rise && bus.sclk_fall));

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb/tb_spi_slave_ctrl.sv - self-checking bench for spi_slave_ctrl with memory model and SPI master driver
module tb_spi_slave_ctrl;
  import spi_pkg::*;

  localparam int AW   = 7;
  localparam int DW   = 8;
  localparam int HALF = 4;
`ifdef SPI_BURST_EN
  localparam int BURST = 1;
`else
  localparam int BURST = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_slave_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  spi_slave_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // synchronous RAM attached to the memory port
  logic [DW-1:0] ram [2**AW];
  always @(posedge clk) begin
    if (bus.wr_en) ram[bus.mem_addr] <= bus.wr_data;
    bus.rd_data <= ram[bus.mem_addr];
  end

  // every write strobe seen, as {addr, data}
  logic [AW+DW-1:0] wr_q [$];
  always @(negedge clk) begin
    if (rst_n && bus.wr_en) wr_q.push_back({bus.mem_addr, bus.wr_data});
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // one SCLK period: set MOSI, rise (sample MISO), fall
  task automatic spi_bit(input logic mo, output logic mi, output logic oe);
    bus.mosi = mo;
    repeat (HALF) @(negedge clk);
    bus.sclk_rise = 1'b1;
    mi = bus.miso;
    oe = bus.miso_oe;
    @(negedge clk);
    bus.sclk_rise = 1'b0;
    repeat (HALF) @(negedge clk);
    bus.sclk_fall = 1'b1;
    @(negedge clk);
    bus.sclk_fall = 1'b0;
  endtask

  task automatic xfer(input logic [AW-1:0] addr, input logic rw, input int nbits,
                      input logic [15:0] wd, output logic [15:0] rb, output int oe_err);
    logic [AW:0] hdr;
    logic mi, oe;
    hdr    = {addr, rw};
    rb     = '0;
    oe_err = 0;
    bus.cs_n = 1'b0;
    for (int i = AW; i >= 0; i--) spi_bit(hdr[i], mi, oe);
    for (int i = 0; i < nbits; i++) begin
      spi_bit(wd[15-i], mi, oe);
      rb[15-i] = mi;
      if (i < DW && oe !== rw) oe_err++;
    end
    repeat (HALF) @(negedge clk);
    bus.cs_n = 1'b1;
    @(negedge clk);
    check("idle_after_cs", 32'(dut.state), 32'(S_IDLE));
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic          rw;
    logic [DW-1:0] wdat;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t          vt [7];
  logic [DW-1:0] exp_mem [2**AW];
  logic [AW-1:0] wlist [$];
  logic [15:0]   rb;
  int            oe_err;
  int            n0;

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    n0 = wr_q.size();
    xfer(a, 1'b0, DW, {d, 8'h00}, rb, oe_err);
    check("wr_oe_low", 32'(oe_err), 0);
    check("wr_count", 32'(wr_q.size() - n0), 1);
    if (wr_q.size() > n0) check("wr_addr_data", 32'(wr_q[n0]), 32'({a, d}));
    check("wr_mem_addr", 32'(bus.mem_addr), 32'(AW'(a + AW'(BURST))));
    exp_mem[a] = d;
    wlist.push_back(a);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] e);
    n0 = wr_q.size();
    xfer(a, 1'b1, DW, 16'h0000, rb, oe_err);
    check("rd_oe_high", 32'(oe_err), 0);
    check("rd_bits", 32'(rb[15:8]), 32'(e));
    check("rd_no_write", 32'(wr_q.size() - n0), 0);
    check("rd_mem_addr", 32'(bus.mem_addr), 32'(AW'(a + AW'(BURST))));
  endtask

  initial begin
    logic mi, oe;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;

    bus.cs_n = 1'b1;
    bus.sclk_rise = 1'b0;
    bus.sclk_fall = 1'b0;
    bus.mosi = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mem_addr", 32'(bus.mem_addr), 0);
    check("rst_wr_en", 32'(bus.wr_en), 0);
    check("rst_wr_data", 32'(bus.wr_data), 0);
    check("rst_miso", 32'(bus.miso), 0);
    check("rst_miso_oe", 32'(bus.miso_oe), 0);
    check("rst_state", 32'(dut.state), 32'(S_IDLE));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    vt[0] = '{addr: 7'h2A, rw: 1'b0, wdat: 8'hC3, exp_rd: 8'h00};
    vt[1] = '{addr: 7'h2A, rw: 1'b0, wdat: 8'hA5, exp_rd: 8'h00};
    vt[2] = '{addr: 7'h2A, rw: 1'b1, wdat: 8'h00, exp_rd: 8'hA5};
    vt[3] = '{addr: 7'h00, rw: 1'b0, wdat: 8'hFF, exp_rd: 8'h00};
    vt[4] = '{addr: 7'h7F, rw: 1'b0, wdat: 8'h01, exp_rd: 8'h00};
    vt[5] = '{addr: 7'h00, rw: 1'b1, wdat: 8'h00, exp_rd: 8'hFF};
    vt[6] = '{addr: 7'h7F, rw: 1'b1, wdat: 8'h00, exp_rd: 8'h01};
    for (int i = 0; i < 7; i++) begin
      if (vt[i].rw) do_read(vt[i].addr, vt[i].exp_rd);
      else          do_write(vt[i].addr, vt[i].wdat);
    end

    // randomized traffic against the memory model
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        ra = AW'($urandom_range(0, 2**AW - 1));
        rd = DW'($urandom_range(0, 255));
        do_write(ra, rd);
      end else begin
        ra = wlist[$urandom_range(0, wlist.size() - 1)];
        do_read(ra, exp_mem[ra]);
      end
    end

    // abort after 5 data bits of a write: no strobe, address untouched
    n0 = wr_q.size();
    xfer(7'h2A, 1'b0, 5, 16'hFFFF, rb, oe_err);
    check("abort_no_write", 32'(wr_q.size() - n0), 0);
    check("abort_mem_addr", 32'(bus.mem_addr), 32'h2A);
    do_read(7'h2A, exp_mem[7'h2A]);

    // reset in the middle of a header
    bus.cs_n = 1'b0;
    for (int i = 0; i < 3; i++) spi_bit(1'b1, mi, oe);
    rst_n = 1'b0;
    #1;
    check("midrst_mem_addr", 32'(bus.mem_addr), 0);
    check("midrst_wr_en", 32'(bus.wr_en), 0);
    check("midrst_wr_data", 32'(bus.wr_data), 0);
    check("midrst_miso", 32'(bus.miso), 0);
    check("midrst_miso_oe", 32'(bus.miso_oe), 0);
    bus.cs_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_state", 32'(dut.state), 32'(S_IDLE));
    do_read(7'h2A, exp_mem[7'h2A]);

    // two data words at 0x7F: a burst wraps to 0x00, a single-word build ignores the second
    n0 = wr_q.size();
    xfer(7'h7F, 1'b0, 16, 16'h1122, rb, oe_err);
    check("two_oe_low", 32'(oe_err), 0);
    check("two_count", 32'(wr_q.size() - n0), 32'(1 + BURST));
    if (wr_q.size() > n0) check("two_first", 32'(wr_q[n0]), 32'({7'h7F, 8'h11}));
    exp_mem[7'h7F] = 8'h11;
`ifdef SPI_BURST_EN
    if (wr_q.size() > n0 + 1) check("two_second", 32'(wr_q[n0+1]), 32'({7'h00, 8'h22}));
    check("two_mem_addr", 32'(bus.mem_addr), 32'h01);
    exp_mem[7'h00] = 8'h22;
`else
    check("two_mem_addr", 32'(bus.mem_addr), 32'h7F);
`endif
    do_read(7'h7F, exp_mem[7'h7F]);
    do_read(7'h00, exp_mem[7'h00]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
